// File: rtl/ifu_pcgen.sv
// Instruction-fetch / PC-generation stage: one fetch in flight, buffers the returned word
// for the decode stage and picks the next PC from the decode-stage redirect at handoff.
module ifu_pcgen #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              inst_misalign_o,
  input  logic              branch_en_i,
  input  logic [ADDR_W-1:0] dnpc_i,
  output logic [1:0]        dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Valid is a Moore output and never waits on ready; payload is held stable while
  // valid is high and ready is low. imem_rsp_valid_i is a ready-less 1-cycle pulse.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] inst_q;
  logic              idu_hs;

  assign idu_hs = (state == S_HOLD) && inst_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ:  if (imem_req_ready_i) state_nxt = S_WAIT;
      S_WAIT: if (imem_rsp_valid_i) state_nxt = S_HOLD;
      S_HOLD: if (inst_ready_i)     state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid_o = (state == S_REQ);
    inst_valid_o     = (state == S_HOLD);
    inst_misalign_o  = (state == S_HOLD) && (|pc[1:0]);
    dbg_state_o      = state;
  end

  // Redirect target is kept verbatim so a misaligned target is still reported downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pc <= RESET_PC;
    else if (idu_hs) pc <= branch_en_i ? dnpc_i : pc + ADDR_W'(4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      inst_q <= '0;
    else if ((state == S_WAIT) && imem_rsp_valid_i) inst_q <= imem_rdata_i;
  end

  assign imem_addr_o = {pc[ADDR_W-1:2], 2'b00};
  assign inst_o      = inst_q;
  assign pc_o        = pc;

endmodule

// File: tb/tb_ifu_pcgen.sv
// Bench for ifu_pcgen: randomized memory/decode-stage behaviour against a transaction-level
// model of fetch order, PC sequencing and handshake timing.
module tb_ifu_pcgen;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o, inst_ready_i;
  logic [31:0] inst_o, pc_o;
  logic        inst_misalign_o;
  logic        branch_en_i;
  logic [31:0] dnpc_i;
  logic [1:0]  dbg_state_o;

  ifu_pcgen #(.ADDR_W(32), .INST_W(32), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rdata_i     (imem_rdata_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .inst_misalign_o  (inst_misalign_o),
    .branch_en_i      (branch_en_i),
    .dnpc_i           (dnpc_i),
    .dbg_state_o      (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: fetched words awaiting handoff, expected PC, expected handshake phase
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  bit          m_idle, m_req, m_hold, outstanding;
  int          rsp_cnt, hs_cnt;

  // stimulus knobs
  int          req_rdy_pct, inst_rdy_pct, lat_min, lat_max, br_mode;
  logic [31:0] dnpc_val;
  bit          force_stray;

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function logic [31:0] pick_dnpc();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000 | ($urandom & 32'h0000_0fff);
      1:       return 32'hffff_fffc;
      default: return RESET_PC + ($urandom_range(0, 255) << 2);
    endcase
  endfunction

  // One clock: check outputs against the model, drive inputs for the next edge,
  // advance the model across that edge.
  task step();
    bit rsp_real;
    bit n_req, n_hold;
    chk("req_valid", imem_req_valid_o, m_req);
    chk("inst_valid", inst_valid_o, m_hold);
    chk("pc_o", pc_o, exp_pc);
    if (m_req) chk("imem_addr", imem_addr_o, {exp_pc[31:2], 2'b00});
    if (m_hold) begin
      chk("inst_o", inst_o, exp_q[0]);
      chk("misalign", inst_misalign_o, |exp_pc[1:0]);
    end

    rsp_real = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rdata_i = $urandom;
    if (outstanding) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        rsp_real = 1'b1;
        imem_rsp_valid_i = 1'b1;
        exp_q.push_back(imem_rdata_i);
      end
    end else if (force_stray || $urandom_range(0, 9) == 0) begin
      imem_rsp_valid_i = 1'b1;
    end
    imem_req_ready_i = ($urandom_range(0, 99) < req_rdy_pct);
    inst_ready_i     = ($urandom_range(0, 99) < inst_rdy_pct);
    dnpc_i           = (br_mode == 0) ? pick_dnpc() : dnpc_val;
    branch_en_i      = (br_mode == 2) ? 1'b1 : (br_mode == 1) ? 1'b0 : ($urandom_range(0, 9) < 3);

    n_req  = m_req;
    n_hold = m_hold;
    if (m_idle) begin
      m_idle = 1'b0;
      n_req  = 1'b1;
    end
    if (m_req && imem_req_ready_i) begin
      n_req       = 1'b0;
      outstanding = 1'b1;
      rsp_cnt     = $urandom_range(lat_min, lat_max);
    end
    if (rsp_real) begin
      outstanding = 1'b0;
      n_hold      = 1'b1;
    end
    if (m_hold && inst_ready_i) begin
      void'(exp_q.pop_front());
      exp_pc = branch_en_i ? dnpc_i : exp_pc + 32'd4;
      n_hold = 1'b0;
      n_req  = 1'b1;
      hs_cnt++;
    end
    m_req  = n_req;
    m_hold = n_hold;
    @(posedge clk);
    #1;
  endtask

  task do_reset(input int cycles);
    rst = 1'b1;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    inst_ready_i = 1'b0;
    branch_en_i = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid_o, 1'b0);
    chk("rst_inst_valid", inst_valid_o, 1'b0);
    exp_q.delete();
    exp_pc = RESET_PC;
    m_idle = 1'b1; m_req = 1'b0; m_hold = 1'b0;
    outstanding = 1'b0; rsp_cnt = 0;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_pc", pc_o, RESET_PC);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_addr", imem_addr_o, RESET_PC);
    rst = 1'b0;
  endtask

  task run_hs(input int n);
    int target;
    int guard;
    target = hs_cnt + n;
    guard = 0;
    while (hs_cnt < target && guard < 40 * n + 40) begin
      step();
      guard++;
    end
    if (hs_cnt < target) chk("hs_timeout", hs_cnt, target);
  endtask

  // what: 0 = until instruction presented, 1 = until fetch outstanding
  task run_until(input int what);
    int guard;
    guard = 0;
    while (((what == 0) ? !m_hold : !outstanding) && guard < 100) begin
      step();
      guard++;
    end
    if (what == 0 && !m_hold) chk("hold_timeout", inst_valid_o, 1'b1);
    if (what == 1 && !outstanding) chk("wait_timeout", imem_req_valid_o, 1'b0);
  endtask

  initial begin
    hs_cnt = 0;
    req_rdy_pct = 100; inst_rdy_pct = 100; lat_min = 1; lat_max = 1;
    br_mode = 1; dnpc_val = 32'h8000_0100; force_stray = 1'b0;
    imem_rdata_i = '0; dnpc_i = '0;
    do_reset(3);

    // sequential fetches, then redirect taken / not taken with the same target
    run_hs(2);
    br_mode = 2; run_hs(1);
    br_mode = 1; run_hs(1);

    // back-pressure on both sides
    req_rdy_pct = 0;
    repeat (4) step();
    req_rdy_pct = 100; inst_rdy_pct = 0;
    run_until(0);
    repeat (5) step();
    inst_rdy_pct = 100; run_hs(1);

    // wrap-around and misaligned redirect
    br_mode = 2; dnpc_val = 32'hffff_fffc; run_hs(1);
    br_mode = 1; run_hs(2);
    br_mode = 2; dnpc_val = 32'h8000_0102; run_hs(1);
    run_until(0);
    br_mode = 1; run_hs(1);

    // reset while a fetch is outstanding; the late response must be dropped
    lat_min = 4; lat_max = 4;
    run_until(1);
    do_reset(2);
    force_stray = 1'b1; req_rdy_pct = 0;
    repeat (3) step();
    force_stray = 1'b0; req_rdy_pct = 100; lat_min = 1; lat_max = 3;
    run_hs(2);

    // randomized traffic
    req_rdy_pct = 60; inst_rdy_pct = 50; br_mode = 0;
    run_hs(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
